// File: rtl/fx2_fifo_pkg.sv
// Shared types for the FX2 slave-FIFO scheduler: FSM encoding, FIFO addresses, requester codes.
package fx2_fifo_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RD_OE,
    ST_RD_STB,
    ST_RD_REL,
    ST_WR_STB,
    ST_WR_REL,
    ST_PKEND,
    ST_DONE
  } fsm_state_t;

  typedef enum logic [1:0] {
    REQ_EP2 = 2'd0,
    REQ_EP6 = 2'd1,
    REQ_EP8 = 2'd2
  } req_idx_t;

  localparam logic [1:0] ADR_EP2 = 2'b00;
  localparam logic [1:0] ADR_EP6 = 2'b10;
  localparam logic [1:0] ADR_EP8 = 2'b11;

  function automatic logic [1:0] req_to_adr(input req_idx_t r);
    case (r)
      REQ_EP6: return ADR_EP6;
      REQ_EP8: return ADR_EP8;
      default: return ADR_EP2;
    endcase
  endfunction

  // Rotation order EP2 -> EP6 -> EP8 -> EP2.
  function automatic req_idx_t next_req(input req_idx_t r);
    case (r)
      REQ_EP2: return REQ_EP6;
      REQ_EP6: return REQ_EP8;
      default: return REQ_EP2;
    endcase
  endfunction

endpackage

// File: rtl/fx2_fifo_scheduler_rr_grant.sv
// Three-way round-robin priority encoder: first eligible requester at or after rr_ptr wins.
module fx2_rr_grant
  import fx2_fifo_pkg::*;
(
  input  logic [2:0] eligible,
  input  req_idx_t   rr_ptr,
  output req_idx_t   grant,
  output logic       valid
);

  always_comb begin
    valid = |eligible;
    grant = REQ_EP2;
    case (rr_ptr)
      REQ_EP6: begin
        if (eligible[1])      grant = REQ_EP6;
        else if (eligible[2]) grant = REQ_EP8;
        else                  grant = REQ_EP2;
      end
      REQ_EP8: begin
        if (eligible[2])      grant = REQ_EP8;
        else if (eligible[0]) grant = REQ_EP2;
        else                  grant = REQ_EP6;
      end
      default: begin
        if (eligible[0])      grant = REQ_EP2;
        else if (eligible[1]) grant = REQ_EP6;
        else                  grant = REQ_EP8;
      end
    endcase
  end

endmodule

// File: rtl/fx2_fifo_scheduler.sv
// FX2 slave-FIFO bus scheduler: round-robin, burst-limited sharing of EP2 reads and EP6/EP8 writes.
// Optional FX2_PKEND_EN adds per-IN-endpoint idle timers that commit short packets via PKEND.
module fx2_fifo_scheduler
  import fx2_fifo_pkg::*;
#(
  parameter int BURST_MAX     = 8,
  parameter int ADR_SETTLE    = 2,
  parameter int PKEND_TIMEOUT = 1024
) (
  input  logic        IFCLK,
  input  logic        RESET,
  input  logic        FLAGA,
  input  logic        FLAGB,
  input  logic        FLAGC,
  inout  wire  [15:0] FX2_FD,
  output logic [1:0]  FIFO_ADR,
  output logic        SLRD,
  output logic        SLWR,
  output logic        SLOE,
  output logic        PKEND,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx6_data,
  input  logic        tx6_req,
  output logic        tx6_ack,
  input  logic [15:0] tx8_data,
  input  logic        tx8_req,
  output logic        tx8_ack,
  output fsm_state_t  state,
  output logic        txden
);

  // Handshakes: rx_valid pulses one cycle per word and is only issued while rx_ready was high when the
  // read was launched; txN_ack pulses one cycle when txN_data has been strobed, and the requester then
  // presents its next word (or drops txN_req) before the following cycle.
  localparam logic [7:0] SETTLE_LAST = 8'(ADR_SETTLE - 1);
  localparam logic [7:0] BEAT_MAX    = 8'(BURST_MAX);

  logic [2:0]  eligible;
  req_idx_t    rr_ptr, cur, grant;
  logic        grant_valid, is_commit;
  logic [7:0]  beat, settle_cnt;
  logic [15:0] fd_out, cur_data;
  logic        cur_more, commit6, commit8;

  assign eligible = {tx8_req & FLAGB, tx6_req & FLAGC, FLAGA & rx_ready};
  assign cur_data = (cur == REQ_EP8) ? tx8_data : tx6_data;
  assign cur_more = (cur == REQ_EP8) ? eligible[2] : eligible[1];
  assign FX2_FD   = txden ? fd_out : 16'hzzzz;

  fx2_rr_grant u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .valid    (grant_valid)
  );

`ifdef FX2_PKEND_EN
  localparam int PW = $clog2(PKEND_TIMEOUT + 1);
  localparam logic [PW-1:0] IDLE_MAX = PW'(PKEND_TIMEOUT);

  logic [PW-1:0] idle6, idle8;
  logic          dirty6, dirty8;

  assign commit6 = dirty6 && (idle6 == IDLE_MAX);
  assign commit8 = dirty8 && (idle8 == IDLE_MAX);

  // Idle counters saturate; dirty marks an IN endpoint holding an uncommitted partial packet.
  always_ff @(negedge IFCLK) begin
    if (RESET) begin
      idle6  <= '0;
      idle8  <= '0;
      dirty6 <= 1'b0;
      dirty8 <= 1'b0;
    end else begin
      if (tx6_ack) begin
        idle6  <= '0;
        dirty6 <= 1'b1;
      end else begin
        if (idle6 != IDLE_MAX) idle6 <= idle6 + PW'(1);
        if (state == ST_PKEND && cur == REQ_EP6) dirty6 <= 1'b0;
      end
      if (tx8_ack) begin
        idle8  <= '0;
        dirty8 <= 1'b1;
      end else begin
        if (idle8 != IDLE_MAX) idle8 <= idle8 + PW'(1);
        if (state == ST_PKEND && cur == REQ_EP8) dirty8 <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (PKEND_TIMEOUT != 0);
  assign commit6 = 1'b0;
  assign commit8 = 1'b0;
`endif

  // All bus state moves on the falling IFCLK edge so strobes are stable at the FX2's rising edge.
  always_ff @(negedge IFCLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      rr_ptr     <= REQ_EP2;
      cur        <= REQ_EP2;
      is_commit  <= 1'b0;
      beat       <= '0;
      settle_cnt <= '0;
      FIFO_ADR   <= ADR_EP2;
      SLRD       <= 1'b1;
      SLWR       <= 1'b1;
      SLOE       <= 1'b1;
      PKEND      <= 1'b1;
      txden      <= 1'b0;
      fd_out     <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx6_ack    <= 1'b0;
      tx8_ack    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx6_ack  <= 1'b0;
      tx8_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          settle_cnt <= '0;
          beat       <= '0;
          if (commit6 || commit8) begin
            is_commit <= 1'b1;
            cur       <= commit6 ? REQ_EP6 : REQ_EP8;
            FIFO_ADR  <= commit6 ? ADR_EP6 : ADR_EP8;
            state     <= ST_SETTLE;
          end else if (grant_valid) begin
            is_commit <= 1'b0;
            cur       <= grant;
            FIFO_ADR  <= req_to_adr(grant);
            rr_ptr    <= next_req(grant);
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            if (is_commit) begin
              PKEND <= 1'b0;
              state <= ST_PKEND;
            end else if (cur == REQ_EP2) begin
              SLOE  <= 1'b0;
              state <= ST_RD_OE;
            end else begin
              txden  <= 1'b1;
              fd_out <= cur_data;
              state  <= ST_WR_STB;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_RD_OE: state <= ST_RD_STB;
        ST_RD_STB: begin
          rx_data  <= FX2_FD;
          rx_valid <= 1'b1;
          SLRD     <= 1'b0;
          beat     <= beat + 8'd1;
          state    <= ST_RD_REL;
        end
        ST_RD_REL: begin
          SLRD <= 1'b1;
          if (eligible[0] && beat < BEAT_MAX) begin
            state <= ST_RD_STB;
          end else begin
            SLOE  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_WR_STB: begin
          SLWR <= 1'b0;
          if (cur == REQ_EP8) tx8_ack <= 1'b1;
          else                tx6_ack <= 1'b1;
          beat  <= beat + 8'd1;
          state <= ST_WR_REL;
        end
        ST_WR_REL: begin
          SLWR   <= 1'b1;
          fd_out <= cur_data;
          if (cur_more && beat < BEAT_MAX) begin
            state <= ST_WR_STB;
          end else begin
            txden <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_PKEND: begin
          PKEND <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          SLOE  <= 1'b1;
          txden <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
// Directed bench for fx2_fifo_scheduler with a small FX2 slave-FIFO model and requester models.
module tb_fx2_fifo_scheduler;
  import fx2_fifo_pkg::*;

  localparam int BURST   = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic IFCLK = 1'b0;
  logic RESET = 1'b1;
  always #5 IFCLK = ~IFCLK;

  logic        FLAGA = 1'b0, FLAGB = 1'b0, FLAGC = 1'b0;
  wire  [15:0] fd;
  logic [15:0] fd_drv = '0;
  logic [1:0]  FIFO_ADR;
  logic        SLRD, SLWR, SLOE, PKEND;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [15:0] tx6_data = '0, tx8_data = '0;
  logic        tx6_req = 1'b0, tx8_req = 1'b0;
  logic        tx6_ack, tx8_ack;
  fsm_state_t  state;
  fsm_state_t  prev_state = ST_IDLE;
  logic        txden;

  // FX2 drives FD whenever its output enable is asserted.
  assign fd = SLOE ? 16'hzzzz : fd_drv;

  fx2_fifo_scheduler #(
    .BURST_MAX     (BURST),
    .ADR_SETTLE    (SETTLE),
    .PKEND_TIMEOUT (TIMEOUT)
  ) dut (
    .IFCLK    (IFCLK),
    .RESET    (RESET),
    .FLAGA    (FLAGA),
    .FLAGB    (FLAGB),
    .FLAGC    (FLAGC),
    .FX2_FD   (fd),
    .FIFO_ADR (FIFO_ADR),
    .SLRD     (SLRD),
    .SLWR     (SLWR),
    .SLOE     (SLOE),
    .PKEND    (PKEND),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx6_data (tx6_data),
    .tx6_req  (tx6_req),
    .tx6_ack  (tx6_ack),
    .tx8_data (tx8_data),
    .tx8_req  (tx8_req),
    .tx8_ack  (tx8_ack),
    .state    (state),
    .txden    (txden)
  );

  // ---------------- models and scoreboard ----------------
  logic [15:0] ep2_q[$], tx6_src[$], tx8_src[$];
  logic [15:0] rx_got[$], ep6_got[$], ep8_got[$];
  logic [15:0] exp_q[$], exp6_q[$], exp8_q[$];
  logic [1:0]  grant_log[$];
  int ep6_cap = 64, ep8_cap = 64;
  int checks = 0, errors = 0, cyc = 0;
  int slrd_lows = 0, slwr_lows = 0, ack6_n = 0, ack8_n = 0, bad_drive = 0;
  int pk6_n = 0, pk8_n = 0, ack8_cyc = 0, pk8_cyc = 0;

  always @(posedge IFCLK) begin
    cyc++;
    if (!SLRD) slrd_lows++;
    if (!SLRD && !SLOE && ep2_q.size() != 0) ep2_q.delete(0);
    if (!SLWR) begin
      slwr_lows++;
      if (FIFO_ADR == 2'b10) ep6_got.push_back(fd);
      else if (FIFO_ADR == 2'b11) ep8_got.push_back(fd);
    end
    if (tx6_ack) begin
      ack6_n++;
      if (tx6_src.size() != 0) tx6_src.delete(0);
    end
    if (tx8_ack) begin
      ack8_n++;
      ack8_cyc = cyc;
      if (tx8_src.size() != 0) tx8_src.delete(0);
    end
    if (rx_valid) rx_got.push_back(rx_data);
    if (!PKEND) begin
      if (FIFO_ADR == 2'b10) pk6_n++;
      if (FIFO_ADR == 2'b11) begin
        pk8_n++;
        pk8_cyc = cyc;
      end
    end
    if (txden && (!SLOE || state == ST_IDLE || state == ST_DONE ||
                  state == ST_RD_OE || state == ST_RD_STB || state == ST_RD_REL))
      bad_drive++;
    if (state == ST_RD_OE || (state == ST_WR_STB && prev_state == ST_SETTLE))
      grant_log.push_back(FIFO_ADR);
    prev_state = state;
    FLAGA    = (ep2_q.size() != 0);
    FLAGC    = (ep6_got.size() < ep6_cap);
    FLAGB    = (ep8_got.size() < ep8_cap);
    fd_drv   = (ep2_q.size() != 0) ? ep2_q[0] : 16'h0;
    tx6_req  = (tx6_src.size() != 0);
    tx6_data = (tx6_src.size() != 0) ? tx6_src[0] : 16'h0;
    tx8_req  = (tx8_src.size() != 0);
    tx8_data = (tx8_src.size() != 0) ? tx8_src[0] : 16'h0;
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge IFCLK);
    #2;
  endtask

  task automatic clear_mon();
    rx_got.delete(); ep6_got.delete(); ep8_got.delete();
    exp_q.delete(); exp6_q.delete(); exp8_q.delete();
    grant_log.delete();
    slrd_lows = 0; slwr_lows = 0; ack6_n = 0; ack8_n = 0; bad_drive = 0;
    pk6_n = 0; pk8_n = 0; ack8_cyc = 0; pk8_cyc = 0;
  endtask

  task automatic wait_quiet(input string tag);
    int idle_run = 0;
    int n = 0;
    while (idle_run < 6 && n < 400) begin
      step();
      n++;
      if (state == ST_IDLE && !(FLAGA && rx_ready) && !(tx6_req && FLAGC) && !(tx8_req && FLAGB))
        idle_run++;
      else
        idle_run = 0;
    end
    check({tag, "_quiet"}, 32'(idle_run >= 6), 32'd1);
  endtask

  task automatic check_streams(input string tag);
    check({tag, "_rx_n"}, rx_got.size(), exp_q.size());
    foreach (exp_q[i]) check({tag, "_rx_word"}, 32'(rx_got[i]), 32'(exp_q[i]));
    check({tag, "_ep6_n"}, ep6_got.size(), exp6_q.size());
    foreach (exp6_q[i]) check({tag, "_ep6_word"}, 32'(ep6_got[i]), 32'(exp6_q[i]));
    check({tag, "_ep8_n"}, ep8_got.size(), exp8_q.size());
    foreach (exp8_q[i]) check({tag, "_ep8_word"}, 32'(ep8_got[i]), 32'(exp8_q[i]));
    check({tag, "_bad_drive"}, bad_drive, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [1:0] exp_grants [4];
    bit found;
    exp_grants = '{2'b00, 2'b10, 2'b11, 2'b00};

    repeat (3) step();
    check("rst_slrd", SLRD, 1);
    check("rst_slwr", SLWR, 1);
    check("rst_sloe", SLOE, 1);
    check("rst_pkend", PKEND, 1);
    check("rst_adr", FIFO_ADR, 0);
    check("rst_txden", txden, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_acks", {tx6_ack, tx8_ack}, 0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    RESET = 1'b0;
    step();

    // Contention: everyone eligible, rotation starts at EP2.
    clear_mon();
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ep2_q.push_back(16'h2000 + 16'(i));
      exp_q.push_back(16'h2000 + 16'(i));
    end
    for (int i = 0; i < 4; i++) begin
      tx6_src.push_back(16'h6000 + 16'(i));
      exp6_q.push_back(16'h6000 + 16'(i));
      tx8_src.push_back(16'h8000 + 16'(i));
      exp8_q.push_back(16'h8000 + 16'(i));
    end
    wait_quiet("cont");
    check("cont_grants_n", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check("cont_grant_adr", 32'(grant_log[i]), 32'(exp_grants[i]));
    check("cont_slrd_n", slrd_lows, 8);
    check("cont_slwr_n", slwr_lows, 8);
    check_streams("cont");

    // Single read of three words.
    clear_mon();
    ep2_q.push_back(16'h1111); ep2_q.push_back(16'h2222); ep2_q.push_back(16'h3333);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    wait_quiet("read");
    check("read_grants_n", grant_log.size(), 1);
    check("read_adr", 32'(grant_log[0]), 0);
    check("read_slrd_n", slrd_lows, 3);
    check("read_sloe", SLOE, 1);
    check_streams("read");

    // EP6 goes full after two words.
    clear_mon();
    ep6_cap = 2;
    for (int i = 0; i < 5; i++) tx6_src.push_back(16'h6100 + 16'(i));
    exp6_q.push_back(16'h6100); exp6_q.push_back(16'h6101);
    wait_quiet("drop");
    check("drop_ack6_n", ack6_n, 2);
    check("drop_slwr_n", slwr_lows, 2);
    check("drop_state", 32'(state), 32'(ST_IDLE));
    check_streams("drop");
    tx6_src.delete();
    ep6_cap = 64;
    step();

    // RX backpressure: EP2 has data but consumer is not ready.
    clear_mon();
    rx_ready = 1'b0;
    ep2_q.push_back(16'hBEEF); ep2_q.push_back(16'hCAFE);
    for (int i = 0; i < 3; i++) begin
      tx6_src.push_back(16'h6200 + 16'(i));
      exp6_q.push_back(16'h6200 + 16'(i));
    end
    wait_quiet("bp");
    check("bp_slrd_n", slrd_lows, 0);
    check("bp_ack6_n", ack6_n, 3);
    check_streams("bp");
    ep2_q.delete();
    rx_ready = 1'b1;
    step();

    // Reset while in WR_STB.
    clear_mon();
    for (int i = 0; i < 6; i++) tx8_src.push_back(16'h8100 + 16'(i));
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (state == ST_WR_STB) found = 1'b1;
    end
    check("rstw_reached", 32'(found), 1);
    check("rstw_pre_adr", FIFO_ADR, 2'b11);
    check("rstw_pre_txden", txden, 1);
    RESET = 1'b1;
    step();
    check("rstw_slwr", SLWR, 1);
    check("rstw_txden", txden, 0);
    check("rstw_adr", FIFO_ADR, 0);
    check("rstw_state", 32'(state), 32'(ST_IDLE));
    check("rstw_slwr_n", slwr_lows, 0);
    tx8_src.delete();
    step();
    RESET = 1'b0;
    step();

    // Short EP8 packet followed by a long idle.
    repeat (40) step();
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      tx8_src.push_back(16'h8200 + 16'(i));
      exp8_q.push_back(16'h8200 + 16'(i));
    end
    repeat (80) step();
    check_streams("pk");
    check("pk_ack8_n", ack8_n, 3);
`ifdef FX2_PKEND_EN
    check("pk_ep8_pulses", pk8_n, 1);
    check("pk_ep6_pulses", pk6_n, 0);
    // Last ack clears the counter one cycle later, it then counts to TIMEOUT, IDLE grants, SETTLE runs.
    check("pk_delay", pk8_cyc - ack8_cyc, TIMEOUT + SETTLE + 2);
`else
    check("pk_no_pulses", pk6_n + pk8_n, 0);
`endif
    check("pk_pkend_high", PKEND, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
